// File: rtl/rng_chaos_scroll_gen2.sv
// Multi-scroll chaotic RNG with seed/warm-up sequencing, whitening and a stalling FWFT output FIFO.
// Optional RNG_HEALTH_EN adds a sticky repeat/fixed-point health monitor.
module rng_chaos_scroll_gen2 #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STEP_SHIFT = 3,
  parameter int unsigned DAMP_SHIFT = 4,
  parameter int unsigned WARMUP_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] X_SEED     = 32'hDE78D681,
  parameter logic [31:0] Y_SEED     = 32'hFEEE4640,
  parameter logic [31:0] Z_SEED     = 32'hFE8E511B
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [3:0]          en,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    x_init,
  input  logic [WIDTH-1:0]    y_init,
  input  logic [WIDTH-1:0]    z_init,
  input  logic [23:0]         cfg_scroll,
  input  logic [WARMUP_W-1:0] warmup_cycles,
  output logic [WIDTH-1:0]    rnd_data,
  output logic                rnd_valid,
  input  logic                rnd_ready,
  output logic [WIDTH-1:0]    x,
  output logic [WIDTH-1:0]    y,
  output logic [WIDTH-1:0]    z,
  output logic [1:0]          state_o,
  output logic                health_fail
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ROT_Y = WIDTH / 3;
  localparam int unsigned ROT_Z = 2 * WIDTH / 3;
  localparam logic [WIDTH-1:0] X_RST = WIDTH'(X_SEED);
  localparam logic [WIDTH-1:0] Y_RST = WIDTH'(Y_SEED);
  localparam logic [WIDTH-1:0] Z_RST = WIDTH'(Z_SEED);

  typedef enum logic [1:0] {StIdle = 2'd0, StWarmup = 2'd1, StRun = 2'd2} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    x_q, y_q, z_q;
  logic [WARMUP_W-1:0] cnt_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [WIDTH-1:0]    mem [FIFO_DEPTH];

  logic [WIDTH-1:0] xo, yo, zo, ysh, zsh, xn, yn, zn, s, s_sh, d, d_sh, w;
  logic             full, pop, adv, push, push_ok, hit;

  logic unused_cfg;
  assign unused_cfg = ^{cfg_scroll[23], cfg_scroll[15], cfg_scroll[7]};

  // c = {U[2:0], L[3:0]}; folds the top 6 bits of f back into the scroll window
  function automatic logic [WIDTH-1:0] scroll(input logic [WIDTH-1:0] f, input logic [6:0] c);
    logic [5:0] h, a, b, o;
    h = f[WIDTH-1 -: 6];
    a = h - {c[3], c[3:0], 1'b1};
    b = h - {c[6], c[6], c[6:4], 1'b1};
    o = a[5] ? a : (b[5] ? ~{6{f[WIDTH-6]}} : b);
    return {o, f[WIDTH-7:0]};
  endfunction

  always_comb begin
    xo   = en[1] ? scroll(x_q, cfg_scroll[6:0])   : x_q;
    yo   = en[2] ? scroll(y_q, cfg_scroll[14:8])  : y_q;
    zo   = en[3] ? scroll(z_q, cfg_scroll[22:16]) : z_q;
    // shifts kept in their own statements so >>> stays arithmetic
    ysh  = $signed(yo) >>> STEP_SHIFT;
    zsh  = $signed(zo) >>> STEP_SHIFT;
    xn   = x_q + ysh;
    yn   = y_q + zsh;
    s    = xo + yo + zo;
    s_sh = $signed(s) >>> DAMP_SHIFT;
    d    = s - s_sh;
    d_sh = $signed(d) >>> STEP_SHIFT;
    zn   = z_q - d_sh;
    w    = xn ^ {yn[WIDTH-ROT_Y-1:0], yn[WIDTH-1 -: ROT_Y]}
              ^ {zn[WIDTH-ROT_Z-1:0], zn[WIDTH-1 -: ROT_Z]};
  end

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign rnd_valid = (count_q != '0);
  assign pop       = rnd_valid && rnd_ready;
  // a full FIFO stalls the attractor unless a pop frees a slot this cycle
  assign adv       = en[0] && ((state_q != StRun) || !full || pop);
  assign push      = !seed_load && adv && (state_q == StRun) && push_ok;
  assign rnd_data  = mem[rd_ptr_q];
  assign x         = x_q;
  assign y         = y_q;
  assign z         = z_q;
  assign state_o   = state_q;

`ifdef RNG_HEALTH_EN
  logic             hf_q, prev_valid_q;
  logic [WIDTH-1:0] prev_q;

  assign hit         = (prev_valid_q && (w == prev_q)) || ({xn, yn, zn} == {x_q, y_q, z_q});
  assign push_ok     = !hf_q && !hit;
  assign health_fail = hf_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hf_q         <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_q       <= '0;
    end else if (seed_load) begin
      hf_q         <= 1'b0;
      prev_valid_q <= 1'b0;
    end else if (adv && (state_q == StRun)) begin
      if (hit) hf_q <= 1'b1;
      if (push) begin
        prev_q       <= w;
        prev_valid_q <= 1'b1;
      end
    end
  end
`else
  assign hit         = 1'b0;
  assign push_ok     = 1'b1;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr_q] <= w;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      x_q      <= X_RST;
      y_q      <= Y_RST;
      z_q      <= Z_RST;
      state_q  <= StIdle;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (seed_load) begin
      x_q      <= x_init;
      y_q      <= y_init;
      z_q      <= z_init;
      cnt_q    <= warmup_cycles;
      state_q  <= (warmup_cycles == '0) ? StRun : StWarmup;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (adv && (state_q != StIdle)) begin
        x_q <= xn;
        y_q <= yn;
        z_q <= zn;
        if (state_q == StWarmup) begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == WARMUP_W'(1)) state_q <= StRun;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_chaos_scroll_gen2.sv
// Directed bench for rng_chaos_scroll_gen2: hand vectors plus a cycle model of
// sequencing, FIFO and attractor. Honours RNG_HEALTH_EN when defined.
module tb_rng_chaos_scroll_gen2;

  localparam int DEPTH = 4;
`ifdef RNG_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic [3:0]  en;
  logic        seed_load;
  logic [31:0] x_init, y_init, z_init;
  logic [23:0] cfg_scroll;
  logic [15:0] warmup_cycles;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [31:0] x, y, z;
  logic [1:0]  state_o;
  logic        health_fail;

  rng_chaos_scroll_gen2 dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (wb_rst_i),
    .en           (en),
    .seed_load    (seed_load),
    .x_init       (x_init),
    .y_init       (y_init),
    .z_init       (z_init),
    .cfg_scroll   (cfg_scroll),
    .warmup_cycles(warmup_cycles),
    .rnd_data     (rnd_data),
    .rnd_valid    (rnd_valid),
    .rnd_ready    (rnd_ready),
    .x            (x),
    .y            (y),
    .z            (z),
    .state_o      (state_o),
    .health_fail  (health_fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference state
  logic [31:0] mx, my, mz, nx, ny, nz, nw, mprev;
  logic [1:0]  ms;
  int          mcnt;
  logic [31:0] q [$];
  bit          mhf, mpv;
  logic [31:0] hx, hy, hz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] asr(input logic [31:0] v, input int n);
    logic signed [31:0] sv;
    sv = v;
    return sv >>> n;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int k);
    return (v << k) | (v >> (32 - k));
  endfunction

  function automatic logic [31:0] sc(input logic [31:0] f, input logic [7:0] c);
    logic [5:0] h, a, b, o;
    h = f[31:26];
    a = h - {c[3], c[3:0], 1'b1};
    b = h - {c[6], c[6], c[6:4], 1'b1};
    if (a[5])      o = a;
    else if (b[5]) o = {6{~f[26]}};
    else           o = b;
    return {o, f[25:0]};
  endfunction

  task automatic model_calc();
    logic [31:0] xo, yo, zo, s, d;
    xo = en[1] ? sc(mx, cfg_scroll[7:0])   : mx;
    yo = en[2] ? sc(my, cfg_scroll[15:8])  : my;
    zo = en[3] ? sc(mz, cfg_scroll[23:16]) : mz;
    nx = mx + asr(yo, 3);
    ny = my + asr(zo, 3);
    s  = xo + yo + zo;
    d  = s - asr(s, 4);
    nz = mz - asr(d, 3);
    nw = nx ^ rotl(ny, 10) ^ rotl(nz, 21);
  endtask

  task automatic model_reset();
    mx = 32'hDE78D681; my = 32'hFEEE4640; mz = 32'hFE8E511B;
    ms = 2'd0; mcnt = 0; q.delete(); mhf = 1'b0; mpv = 1'b0; mprev = '0;
  endtask

  // applies one clock edge to the reference using the currently driven inputs
  task automatic model_edge();
    bit pop, full, adv;
    pop  = (q.size() != 0) && rnd_ready;
    full = (q.size() == DEPTH);
    if (seed_load) begin
      mx = x_init; my = y_init; mz = z_init;
      q.delete(); mcnt = int'(warmup_cycles);
      ms = (warmup_cycles == 0) ? 2'd2 : 2'd1;
      mhf = 1'b0; mpv = 1'b0;
      return;
    end
    if (pop) void'(q.pop_front());
    adv = en[0] && (ms != 2'd2 || !full || pop);
    if (ms == 2'd0 || !adv) return;
    model_calc();
    if (ms == 2'd2) begin
`ifdef RNG_HEALTH_EN
      if ((mpv && nw == mprev) || (nx == mx && ny == my && nz == mz)) mhf = 1'b1;
      if (!mhf) begin
        q.push_back(nw);
        mprev = nw;
        mpv   = 1'b1;
      end
`else
      q.push_back(nw);
`endif
    end else begin
      mcnt--;
      if (mcnt == 0) ms = 2'd2;
    end
    mx = nx; my = ny; mz = nz;
  endtask

  task automatic check_all();
    check("x", x, mx);
    check("y", y, my);
    check("z", z, mz);
    check("state", state_o, ms);
    check("valid", rnd_valid, q.size() != 0);
    check("health", health_fail, mhf);
    if (q.size() != 0) check("data", rnd_data, q[0]);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic seed(input logic [31:0] xi, yi, zi, input logic [15:0] wu);
    x_init = xi; y_init = yi; z_init = zi; warmup_cycles = wu;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    en = 4'h0; seed_load = 1'b0; x_init = '0; y_init = '0; z_init = '0;
    cfg_scroll = '0; warmup_cycles = '0; rnd_ready = 1'b0;
    wb_rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_x", x, 32'hDE78D681);
    check("rst_y", y, 32'hFEEE4640);
    check("rst_z", z, 32'hFE8E511B);
    check("rst_valid", rnd_valid, 1'b0);
    check("rst_state", state_o, 2'd0);
    check("rst_health", health_fail, 1'b0);
    wb_rst_i = 1'b0;

    // IDLE ignores iterate enable
    en = 4'hF;
    repeat (2) step();

    // bypass hand vector: (0,8,0) -> (1,8,-1) -> (2,7,-2)
    en = 4'h1;
    seed(32'h0, 32'h8, 32'h0, 16'd0);
    check("wu0_state", state_o, 2'd2);
    step();
    check("hv_w0", rnd_data, 32'hFFFFDFFE);
    check("hv_x1", x, 32'h1);
    check("hv_z1", z, 32'hFFFFFFFF);
    step();
    check("hv_x2", x, 32'h2);
    check("hv_y2", y, 32'h7);
    check("hv_z2", z, 32'hFFFFFFFE);

    // scroll hand vector on x only: xo = 0x1C000000
    en = 4'h3; cfg_scroll = 24'h4d4c4b;
    seed(32'h0, 32'h0, 32'h0, 16'd0);
    step();
    check("sc_w0", rnd_data, 32'h001F9700);
    check("sc_x1", x, 32'h0);
    check("sc_z1", z, 32'hFCB80000);

    // warm-up latency, then backpressure
    en = 4'hF;
    seed(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 16'd5);
    check("wu_state0", state_o, 2'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("wu_state", state_o, (i < 5) ? 2'd1 : 2'd2);
      check("wu_valid", rnd_valid, 1'b0);
    end
    step();
    check("wu_valid6", rnd_valid, 1'b1);
    repeat (3) step();
    hx = mx; hy = my; hz = mz;
    repeat (3) step();
    check("bp_hold_x", x, hx);
    check("bp_hold_y", y, hy);
    check("bp_hold_z", z, hz);
    check("bp_valid", rnd_valid, 1'b1);
    rnd_ready = 1'b1;
    repeat (10) step();
    rnd_ready = 1'b0;

    // en[0]=0 freezes counter mid warm-up
    seed(32'hCAFEBABE, 32'h13579BDF, 32'h2468ACE0, 16'd10);
    step();
    hx = mx;
    en = 4'hE;
    repeat (3) step();
    check("en0_state", state_o, 2'd1);
    check("en0_x", x, hx);
    en = 4'hF;
    repeat (8) step();
    check("en0_warm", state_o, 2'd1);
    step();
    check("en0_run", state_o, 2'd2);

    // seed_load while full and popping
    seed(32'h11111111, 32'h22222222, 32'h33333333, 16'd0);
    repeat (5) step();
    rnd_ready = 1'b1;
    seed(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h3C3C3C3C, 16'd0);
    check("sl_valid", rnd_valid, 1'b0);
    check("sl_x", x, 32'hA5A5A5A5);
    check("sl_y", y, 32'h5A5A5A5A);
    check("sl_z", z, 32'h3C3C3C3C);
    rnd_ready = 1'b0;
    repeat (3) step();

    // asynchronous reset mid-cycle
    #3 wb_rst_i = 1'b1;
    #1;
    check("ar_x", x, 32'hDE78D681);
    check("ar_y", y, 32'hFEEE4640);
    check("ar_z", z, 32'hFE8E511B);
    check("ar_valid", rnd_valid, 1'b0);
    check("ar_state", state_o, 2'd0);
    model_reset();
    #2 wb_rst_i = 1'b0;
    step();

    // fixed point: health monitor trips when built in, otherwise pushes continue
    en = 4'h1;
    seed(32'h0, 32'h0, 32'h0, 16'd0);
    step();
    check("hf_set", health_fail, HEALTH);
    check("hf_push", rnd_valid, !HEALTH);
    repeat (2) step();
    check("hf_sticky", health_fail, HEALTH);
    seed(32'h1, 32'h2, 32'h3, 16'd0);
    check("hf_clear", health_fail, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
